// File: rtl/rv_fetch_queue_if.sv
// Fetch queue bus: fetcher push side plus decoder head/pop side.
// The queue takes the slave modport; fetcher/decoder logic takes master.
interface rv_fetch_queue_if #(
   parameter int IADDR_SPACE_BITS = 16,
   parameter int DEPTH_BITS = 3,
   parameter int PUSH_HALFS = 2
);
   localparam int PCW = IADDR_SPACE_BITS - 1;
   localparam int CW = $clog2(PUSH_HALFS + 1);

   logic                     i_flush;
   logic [PCW-1:0]           i_flush_pc;
   logic [16*PUSH_HALFS-1:0] i_data;
   logic [CW-1:0]            i_push_cnt;
   logic                     i_push_err;
   logic [DEPTH_BITS:0]      o_free_cnt;
   logic                     o_overflow;
   logic [31:0]              o_instr;
   logic                     o_instr_valid;
   logic                     o_instr_comp;
   logic [PCW-1:0]           o_pc;
   logic [PCW-1:0]           o_pc_next;
   logic                     o_err;
   logic                     i_pop;

   modport master (
      output i_flush, i_flush_pc, i_data,
      output i_push_cnt, i_push_err, i_pop,
      input  o_free_cnt, o_overflow, o_instr,
      input  o_instr_valid, o_instr_comp,
      input  o_pc, o_pc_next, o_err
   );

   modport slave (
      input  i_flush, i_flush_pc, i_data,
      input  i_push_cnt, i_push_err, i_pop,
      output o_free_cnt, o_overflow, o_instr,
      output o_instr_valid, o_instr_comp,
      output o_pc, o_pc_next, o_err
   );
endinterface

// File: rtl/rv_fetch_queue.sv
// Halfword fetch queue presenting one RVC/RV32 instruction at the head.
// Define RV_FETCH_QUEUE_ERR_EN to store and report per-halfword fetch errors.
module rv_fetch_queue #(
   parameter int IADDR_SPACE_BITS = 16,
   parameter int DEPTH_BITS = 3,
   parameter int PUSH_HALFS = 2,
   parameter logic [IADDR_SPACE_BITS-1:0] RESET_PC = '0
) (
   input logic i_clk,
   input logic i_reset_n,
   rv_fetch_queue_if.slave bus
);
   localparam int PCW = IADDR_SPACE_BITS - 1;
   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] DEPTH_C =
      (DEPTH_BITS+1)'(DEPTH);

   typedef logic [DEPTH_BITS-1:0] ptr_t;
   typedef logic [DEPTH_BITS:0]   cnt_t;

   logic [15:0]    mem_q [DEPTH];
   ptr_t           rd_q, rd_d, wr_q, wr_d, rd1;
   cnt_t           cnt_q, cnt_d, free, push_n, pop_n;
   logic [PCW-1:0] pc_q, pc_d, pc_nx;
   logic           ovf_q, ovf_d;
   logic [15:0]    lo, hi;
   logic           comp, valid, pop;
   logic           push_any, push_ok, wr_en;

   assign rd1 = rd_q + ptr_t'(1);
   assign lo = mem_q[rd_q];
   assign hi = mem_q[rd1];
   assign comp = lo[1:0] != 2'b11;
   assign valid = (cnt_q != '0 && comp) ||
                  cnt_q >= cnt_t'(2);
   assign free = DEPTH_C - cnt_q;
   assign pc_nx = pc_q + (comp ? PCW'(1) : PCW'(2));

   // Space is judged on the pre-pop count.
   assign push_n = cnt_t'(bus.i_push_cnt);
   assign push_any = push_n != '0;
   assign push_ok = push_any && push_n <= free;
   assign wr_en = push_ok && !bus.i_flush;
   assign pop = bus.i_pop && valid;
   assign pop_n = !pop ? '0 :
                  comp ? cnt_t'(1) : cnt_t'(2);

   always_comb begin
      rd_d = rd_q + ptr_t'(pop_n);
      wr_d = wr_q;
      cnt_d = cnt_q - pop_n;
      pc_d = pop ? pc_nx : pc_q;
      ovf_d = push_any && !push_ok;
      if (push_ok) begin
         wr_d = wr_q + ptr_t'(push_n);
         cnt_d = cnt_q + push_n - pop_n;
      end
      if (bus.i_flush) begin
         rd_d = '0;
         wr_d = '0;
         cnt_d = '0;
         pc_d = bus.i_flush_pc;
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
         pc_q <= RESET_PC[IADDR_SPACE_BITS-1:1];
         ovf_q <= 1'b0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
         pc_q <= pc_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < PUSH_HALFS; i++) begin
         if (wr_en && i < int'(push_n))
            mem_q[wr_q + ptr_t'(i)] <= bus.i_data[16*i +: 16];
      end
   end

`ifdef RV_FETCH_QUEUE_ERR_EN
   logic [DEPTH-1:0] err_q;

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < PUSH_HALFS; i++) begin
         if (wr_en && i < int'(push_n))
            err_q[wr_q + ptr_t'(i)] <= bus.i_push_err;
      end
   end

   assign bus.o_err = cnt_q != '0 &&
      (err_q[rd_q] || (!comp && err_q[rd1]));
`else
   assign bus.o_err = 1'b0 & bus.i_push_err;
`endif

   assign bus.o_free_cnt = free;
   assign bus.o_overflow = ovf_q;
   assign bus.o_instr_valid = valid;
   assign bus.o_instr_comp = comp;
   assign bus.o_pc = pc_q;
   assign bus.o_pc_next = pc_nx;
   assign bus.o_instr = cnt_q == '0 ? 32'h0 :
                        comp ? {16'h0, lo} : {hi, lo};
endmodule

// File: tb/tb_rv_fetch_queue.sv
// Randomised scoreboard bench for rv_fetch_queue.
// Reference model is a queue of halfwords plus a head PC.
module tb_rv_fetch_queue;
   localparam int AW = 16;
   localparam int DB = 3;
   localparam int PH = 2;
   localparam int DEPTH = 8;
   localparam logic [15:0] RPC = 16'h0100;

   typedef struct {
      logic [15:0] d;
      bit          e;
   } half_t;

   typedef struct {
      int          n;
      bit          valid;
      bit          comp;
      logic [31:0] instr;
      logic [14:0] pc;
      logic [14:0] pcn;
      bit          err;
      int          free;
      bit          ovf;
   } st_t;

   typedef struct {
      logic [31:0] instr;
      logic [14:0] pc;
   } ret_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rv_fetch_queue_if #(
      .IADDR_SPACE_BITS(AW),
      .DEPTH_BITS(DB),
      .PUSH_HALFS(PH)
   ) bus ();

   rv_fetch_queue #(
      .IADDR_SPACE_BITS(AW),
      .DEPTH_BITS(DB),
      .PUSH_HALFS(PH),
      .RESET_PC(RPC)
   ) dut (
      .i_clk(clk),
      .i_reset_n(rst_n),
      .bus(bus)
   );

   half_t       hq[$];
   st_t         st_q[$];
   ret_t        ret_q[$];
   logic [14:0] mpc;
   bit          movf;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic drive_cycle(input int pop_pct);
      st_t         s;
      int          n, pc_cnt;
      logic [15:0] hw, lo;
      logic [31:0] dat;
      logic [14:0] fpc;
      bit          fl, pp, er, comp;
      fl = $urandom_range(0, 99) < 2;
      pc_cnt = $urandom_range(0, 2);
      for (int h = 0; h < 2; h++) begin
         hw = 16'($urandom);
         if ($urandom_range(0, 1) == 1) hw[1:0] = 2'b11;
         dat[16*h +: 16] = hw;
      end
      pp = $urandom_range(0, 99) < pop_pct;
      er = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 3) == 0)
         fpc = 15'(15'h7FFE + $urandom_range(0, 1));
      else
         fpc = 15'($urandom);
      bus.i_flush = fl;
      bus.i_flush_pc = fpc;
      bus.i_data = dat;
      bus.i_push_cnt = 2'(pc_cnt);
      bus.i_push_err = er;
      bus.i_pop = pp;

      n = hq.size();
      s = '{default: 0};
      s.n = n;
      s.free = DEPTH - n;
      s.ovf = movf;
      s.pc = mpc;
      comp = 1'b0;
      if (n > 0) begin
         lo = hq[0].d;
         comp = lo[1:0] != 2'b11;
         s.comp = comp;
         s.valid = comp || n >= 2;
         if (s.valid) begin
            s.instr = comp ? {16'h0, lo} : {hq[1].d, lo};
            s.pcn = 15'(mpc + (comp ? 1 : 2));
`ifdef RV_FETCH_QUEUE_ERR_EN
            s.err = hq[0].e | (!comp & hq[1].e);
`endif
         end
      end
      st_q.push_back(s);
      if (!fl && pp && s.valid)
         ret_q.push_back('{s.instr, mpc});

      if (fl) begin
         hq.delete();
         mpc = fpc;
         movf = 1'b0;
      end else begin
         movf = pc_cnt > 0 && pc_cnt > DEPTH - n;
         if (pp && s.valid) begin
            repeat (comp ? 1 : 2) void'(hq.pop_front());
            mpc = s.pcn;
         end
         if (pc_cnt > 0 && pc_cnt <= DEPTH - n)
            for (int h = 0; h < pc_cnt; h++)
               hq.push_back('{dat[16*h +: 16], er});
      end
   endtask

   always @(negedge clk) begin : mon
      st_t  s;
      ret_t r;
      if (st_q.size() > 0) begin
         s = st_q.pop_front();
         chk("free_cnt", 32'(bus.o_free_cnt), 32'(s.free));
         chk("overflow", 32'(bus.o_overflow), 32'(s.ovf));
         chk("valid", 32'(bus.o_instr_valid), 32'(s.valid));
         chk("pc", 32'(bus.o_pc), 32'(s.pc));
         if (s.n == 0) begin
            chk("instr_empty", bus.o_instr, 32'h0);
            chk("err_empty", 32'(bus.o_err), 32'h0);
         end
         if (s.valid) begin
            chk("instr", bus.o_instr, s.instr);
            chk("comp", 32'(bus.o_instr_comp), 32'(s.comp));
            chk("pc_next", 32'(bus.o_pc_next), 32'(s.pcn));
            chk("err", 32'(bus.o_err), 32'(s.err));
         end
         if (bus.i_pop && bus.o_instr_valid && !bus.i_flush) begin
            if (ret_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL retire: got pop of %h expected none",
                        bus.o_instr);
            end else begin
               r = ret_q.pop_front();
               chk("retire_instr", bus.o_instr, r.instr);
               chk("retire_pc", 32'(bus.o_pc), 32'(r.pc));
            end
         end
      end
   end

   initial begin
      bus.i_flush = 1'b0;
      bus.i_flush_pc = '0;
      bus.i_data = '0;
      bus.i_push_cnt = '0;
      bus.i_push_err = 1'b0;
      bus.i_pop = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_free", 32'(bus.o_free_cnt), 32'd8);
      chk("rst_valid", 32'(bus.o_instr_valid), 32'd0);
      chk("rst_ovf", 32'(bus.o_overflow), 32'd0);
      chk("rst_err", 32'(bus.o_err), 32'd0);
      chk("rst_instr", bus.o_instr, 32'h0);
      chk("rst_pc", 32'(bus.o_pc), 32'h80);
      rst_n = 1'b1;
      mpc = 15'(RPC >> 1);
      movf = 1'b0;
      hq.delete();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #2;
         case ((c / 200) % 3)
            0: drive_cycle(15);
            1: drive_cycle(85);
            default: drive_cycle(50);
         endcase
      end
      @(posedge clk);
      #2;
      bus.i_push_cnt = '0;
      bus.i_pop = 1'b0;
      bus.i_flush = 1'b0;
      @(negedge clk);
      #1;
      chk("retire_left", 32'(ret_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
